// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control unit: opcodes, ALU codes, states, mux selects.
package mu0_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] ALU_Y   = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    localparam logic X_ACC = 1'b0;
    localparam logic X_PC  = 1'b1;
    localparam logic Y_MEM = 1'b0;
    localparam logic Y_IR  = 1'b1;
    localparam logic A_PC  = 1'b0;
    localparam logic A_IR  = 1'b1;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic [1:0] m;
        logic       rd;
        logic       wr;
        logic       fetch;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational decode of (state, opcode, flags) into datapath controls,
// before the enables are qualified by the wait-state last cycle.
module mu0_decode
    import mu0_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] f,
    input  logic       n,
    input  logic       z,
    output ctrl_t      ctrl
);

    logic jump;

    always_comb begin
        ctrl = '0;
        jump = 1'b0;
        case (state)
            ST_FETCH: begin
                ctrl.addr_sel = A_PC;
                ctrl.rd       = 1'b1;
                ctrl.x_sel    = X_PC;
                ctrl.m        = ALU_INC;
                ctrl.ir_en    = 1'b1;
                ctrl.pc_en    = 1'b1;
                ctrl.fetch    = 1'b1;
            end
            ST_EXEC: begin
                case (f)
                    OP_LDA: begin
                        ctrl.addr_sel = A_IR;
                        ctrl.rd       = 1'b1;
                        ctrl.y_sel    = Y_MEM;
                        ctrl.m        = ALU_Y;
                        ctrl.acc_en   = 1'b1;
                    end
                    OP_STO: begin
                        ctrl.addr_sel = A_IR;
                        ctrl.wr       = 1'b1;
                        ctrl.x_sel    = X_ACC;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.addr_sel = A_IR;
                        ctrl.rd       = 1'b1;
                        ctrl.x_sel    = X_ACC;
                        ctrl.y_sel    = Y_MEM;
                        ctrl.m        = (f == OP_ADD) ? ALU_ADD : ALU_SUB;
                        ctrl.acc_en   = 1'b1;
                    end
                    OP_JMP:  jump = 1'b1;
                    OP_JGE:  jump = ~n;
                    OP_JNE:  jump = ~z;
                    default: jump = 1'b0;
                endcase
                // An untaken conditional jump drives nothing at all.
                if (jump) begin
                    ctrl.y_sel = Y_IR;
                    ctrl.m     = ALU_Y;
                    ctrl.pc_en = 1'b1;
                end
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 sequencer: fetch/execute state machine with optional memory wait states.
// Each non-halt state is held MEM_WAIT+1 cycles; register enables fire on the last one.
module mu0_control
    import mu0_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic [1:0] M,
    output logic       Rd,
    output logic       Wr,
    output logic       Fetch,
    output logic       Halted
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       last;
    ctrl_t      dec;
    ctrl_t      ctrl;

    assign last = (wait_cnt == WAIT_LAST);

    mu0_decode u_decode (
        .state (state),
        .f     (F),
        .n     (N),
        .z     (Z),
        .ctrl  (dec)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (last || state == ST_HALT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: if (last) state_next = ST_EXEC;
            ST_EXEC:  if (last) state_next = (F == OP_STP) ? ST_HALT : ST_FETCH;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        ctrl = dec;
        ctrl.pc_en  = dec.pc_en  & last;
        ctrl.ir_en  = dec.ir_en  & last;
        ctrl.acc_en = dec.acc_en & last;
        if (Reset)
            ctrl = '0;
    end

    assign X_sel    = ctrl.x_sel;
    assign Y_sel    = ctrl.y_sel;
    assign Addr_sel = ctrl.addr_sel;
    assign PC_En    = ctrl.pc_en;
    assign IR_En    = ctrl.ir_en;
    assign Acc_En   = ctrl.acc_en;
    assign M        = ctrl.m;
    assign Rd       = ctrl.rd;
    assign Wr       = ctrl.wr;
    assign Fetch    = ctrl.fetch;
    assign Halted   = ctrl.halted;

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control at MEM_WAIT=0 and MEM_WAIT=2 against a cycle-position model.
module tb_mu0_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic [3:0] f   [2];
    logic       n   [2];
    logic       z   [2];

    logic       x_sel [2], y_sel [2], addr_sel [2], pc_en [2], ir_en [2], acc_en [2];
    logic [1:0] m     [2];
    logic       rd [2], wr [2], fetch [2], halted [2];
    logic [11:0] act [2];

    mu0_control #(.MEM_WAIT(0)) u0 (
        .Clk(clk), .Reset(rst[0]), .F(f[0]), .N(n[0]), .Z(z[0]),
        .X_sel(x_sel[0]), .Y_sel(y_sel[0]), .Addr_sel(addr_sel[0]),
        .PC_En(pc_en[0]), .IR_En(ir_en[0]), .Acc_En(acc_en[0]), .M(m[0]),
        .Rd(rd[0]), .Wr(wr[0]), .Fetch(fetch[0]), .Halted(halted[0])
    );

    mu0_control #(.MEM_WAIT(2)) u1 (
        .Clk(clk), .Reset(rst[1]), .F(f[1]), .N(n[1]), .Z(z[1]),
        .X_sel(x_sel[1]), .Y_sel(y_sel[1]), .Addr_sel(addr_sel[1]),
        .PC_En(pc_en[1]), .IR_En(ir_en[1]), .Acc_En(acc_en[1]), .M(m[1]),
        .Rd(rd[1]), .Wr(wr[1]), .Fetch(fetch[1]), .Halted(halted[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign act[g] = {x_sel[g], y_sel[g], addr_sel[g], pc_en[g], ir_en[g], acc_en[g],
                         m[g], rd[g], wr[g], fetch[g], halted[g]};
    end

    // Model: position t within the 2*L-cycle instruction (L = MEM_WAIT+1), plus a halted flag.
    int unsigned len [2] = '{1, 3};
    int unsigned m_t [2] = '{0, 0};
    bit          m_h [2] = '{0, 0};

    int checks = 0;
    int passed = 0;

    function automatic logic [11:0] model_out(input logic r, input bit h, input int unsigned t,
                                              input int unsigned l, input logic [3:0] op,
                                              input logic nf, input logic zf);
        logic xs, ys, as, pe, ie, ae, rs, ws, fe;
        logic [1:0] mm;
        bit lc, jump;
        {xs, ys, as, pe, ie, ae, rs, ws, fe} = '0;
        mm = 2'b00;
        jump = 1'b0;
        if (r) return 12'd0;
        if (h) return 12'd1;
        lc = ((t % l) == l - 1);
        if (t < l) begin
            xs = 1; mm = 2'b10; rs = 1; fe = 1; pe = lc; ie = lc;
        end else begin
            case (op)
                4'd0: begin as = 1; rs = 1; ae = lc; end
                4'd1: begin as = 1; ws = 1; end
                4'd2: begin as = 1; rs = 1; mm = 2'b01; ae = lc; end
                4'd3: begin as = 1; rs = 1; mm = 2'b11; ae = lc; end
                4'd4: jump = 1;
                4'd5: jump = !nf;
                4'd6: jump = !zf;
                default: jump = 0;
            endcase
            if (jump) begin ys = 1; pe = lc; end
        end
        return {xs, ys, as, pe, ie, ae, mm, rs, ws, fe, 1'b0};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_t[i] <= 0;
                m_h[i] <= 0;
            end else if (!m_h[i]) begin
                if (m_t[i] == 2 * len[i] - 1) begin
                    m_t[i] <= 0;
                    if (f[i] == 4'd7) m_h[i] <= 1;
                end else begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [11:0] e;
            e = model_out(rst[i], m_h[i], m_t[i], len[i], f[i], n[i], z[i]);
            checks++;
            if (act[i] === e) passed++;
            else $display("FAIL model dut%0d t=%0t: got %b want %b", i, $time, act[i], e);
        end
    end

    localparam logic [11:0] FETCH1 = 12'b100110101010;
    localparam logic [11:0] F_NL   = 12'b100000101010;
    localparam logic [11:0] LDA    = 12'b001001001000;
    localparam logic [11:0] STO    = 12'b001000000100;
    localparam logic [11:0] ADD    = 12'b001001011000;
    localparam logic [11:0] ADD_NL = 12'b001000011000;
    localparam logic [11:0] SUB    = 12'b001001111000;
    localparam logic [11:0] JMP    = 12'b010100000000;
    localparam logic [11:0] HALT   = 12'b000000000001;

    localparam logic [3:0]  DF [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd9, 4'd7};
    localparam logic        DN [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    localparam logic        DZ [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    localparam logic [11:0] DE [11] = '{LDA, STO, ADD, SUB, JMP, 12'd0, JMP, 12'd0, JMP, 12'd0, 12'd0};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input int i, input logic [11:0] e);
        checks++;
        if (act[i] === e) passed++;
        else $display("FAIL %s dut%0d: got %b want %b", name, i, act[i], e);
    endtask

    initial begin
        rst[0] = 1; rst[1] = 1;
        f[0] = 0; f[1] = 0; n[0] = 0; n[1] = 0; z[0] = 0; z[1] = 0;
        repeat (2) next_cycle();
        #3; pin("reset", 0, 12'd0); pin("reset", 1, 12'd0);

        for (int k = 0; k < 11; k++) begin
            next_cycle();
            rst[0] = 0; f[0] = DF[k]; n[0] = DN[k]; z[0] = DZ[k];
            #3; pin("fetch", 0, FETCH1);
            next_cycle();
            #3; pin("exec", 0, DE[k]);
        end
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            #3; pin("halt", 0, HALT);
        end
        next_cycle(); rst[0] = 1;
        #3; pin("halt_reset", 0, 12'd0);
        next_cycle(); rst[0] = 0; f[0] = 0;
        #3; pin("after_halt", 0, FETCH1);
        next_cycle(); rst[0] = 1;

        next_cycle(); rst[1] = 0; f[1] = 4'd2;
        #3; pin("wfetch1", 1, F_NL);
        next_cycle(); #3; pin("wfetch2", 1, F_NL);
        next_cycle(); #3; pin("wfetch3", 1, FETCH1);
        next_cycle(); #3; pin("wexec1", 1, ADD_NL);
        next_cycle(); #3; pin("wexec2", 1, ADD_NL);
        next_cycle(); #3; pin("wexec3", 1, ADD);
        next_cycle(); #3; pin("wnext", 1, F_NL);
        next_cycle(); next_cycle();
        next_cycle(); #3; pin("wexec1b", 1, ADD_NL);
        next_cycle(); rst[1] = 1;
        #3; pin("wreset_mid", 1, 12'd0);
        next_cycle(); rst[1] = 0;
        #3; pin("wrel1", 1, F_NL);
        next_cycle(); #3; pin("wrel2", 1, F_NL);
        next_cycle(); #3; pin("wrel3", 1, FETCH1);

        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            for (int i = 0; i < 2; i++) begin
                rst[i] = ($urandom_range(0, 39) == 0);
                if (m_t[i] == 0)
                    f[i] = ($urandom_range(0, 9) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
                n[i] = 1'($urandom_range(0, 1));
                z[i] = 1'($urandom_range(0, 1));
            end
        end
        next_cycle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
